load_store_unit: RTL

Multi-cycle data-memory sequencer between the single-cycle datapath and a byte-wide external data bus. Consumes mem_read, mem_write and MemCtr from the control unit, plus the ALU address and the $rt store data. Splits each load or store into 1, 2 or 4 byte transfers on a req/ack bus. Holds the core stalled until the access completes, then returns zero-extended load data for register writeback.

---
 rtl/load_store_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Byte-serial load/store sequencer: splits lw/lhu/lbu/sw/sh/sb into req/ack byte transfers.
// Optional misaligned-access rejection is enabled by defining LSU_ALIGN_CHECK_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        MemCtr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              addr_err,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack
);

  localparam int unsigned WaitW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [WaitW-1:0] WaitLast =
      WaitW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [1:0]        last_q;
  logic [1:0]        cnt_q;
  logic [WaitW-1:0]  wait_q;
  logic [31:0]       rdata_q;
  logic              done_q;
  logic              addr_err_q;
  logic              bus_err_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [7:0]        bus_wdata_q;

  logic              req;
  logic [1:0]        last_d;
  logic [1:0]        cnt_nxt;
  logic              misalign;

  assign req     = mem_read | mem_write;
  assign cnt_nxt = cnt_q + 2'd1;

  // Index of the final byte; bit 2 of MemCtr never selects direction.
  always_comb begin
    last_d = 2'd3;
    case (MemCtr)
      3'b001, 3'b101: last_d = 2'd0;
      3'b010, 3'b111: last_d = 2'd1;
      default:        last_d = 2'd3;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = ((last_d == 2'd1) && addr[0]) ||
                    ((last_d == 2'd3) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      wdata_q     <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            base_q  <= addr;
            wdata_q <= wdata;
            last_q  <= last_d;
            cnt_q   <= '0;
            wait_q  <= '0;
            if (misalign) begin
              addr_err_q <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= StDone;
            end else begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_write;
              bus_addr_q  <= addr;
              bus_wdata_q <= wdata[7:0];
              state_q     <= StXfer;
            end
          end
        end
        StXfer: begin
          if (bus_ack) begin
            wait_q <= '0;
            if (!bus_we_q) begin
              // First byte of a load also performs the zero-extension.
              if (cnt_q == 2'd0) rdata_q <= {24'd0, bus_rdata};
              else               rdata_q[{cnt_q, 3'b000} +: 8] <= bus_rdata;
            end
            if (cnt_q == last_q) begin
              bus_req_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= StDone;
            end else begin
              cnt_q       <= cnt_nxt;
              bus_addr_q  <= base_q + ADDR_W'(cnt_nxt);
              bus_wdata_q <= wdata_q[{cnt_nxt, 3'b000} +: 8];
            end
          end else if (TimeoutEn && (wait_q == WaitLast)) begin
            bus_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated by rst_n so a request held through reset does not show as a stall.
  assign stall = rst_n & ((state_q == StXfer) | ((state_q == StIdle) & req));

  assign rdata     = rdata_q;
  assign done      = done_q;
  assign addr_err  = addr_err_q;
  assign bus_err   = bus_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule
